cthulhu_reg_slave: RTL and testbench
====================================

Name: cthulhu_reg_slave

Overview:
- Register-bus slave. It sits directly downstream of the cthulhu register bus (addr/write_en/valid/data_w/data_r) and consumes the transactions driven on it.
- Contains a small control/status register set plus a byte TX FIFO.
- Software fills the FIFO through bus writes; a valid/ready stream port drains it toward downstream datapath logic.
- Raises a level interrupt on FIFO overflow.

Parameters:
- DEPTH, 8, number of FIFO entries. Must be a power of 2 and at least 2.
- ID_VALUE, 8'hC7, constant returned by the ID register.

Ports:
- clk  input  1  single clock; all logic is sampled on posedge.
- rst_n  input  1  reset, synchronous, active-high. The name is kept for bus-wide consistency; asserting it high resets the block on the next posedge.
- addr  input  12  register address.
- write_en  input  1  1 = write, 0 = read; qualified by valid.
- valid  input  1  transaction strobe; one transaction per cycle while high.
- data_w  input  8  write data.
- data_r  output  8  read data, registered.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  stream valid.
- tx_ready  input  1  stream ready from the downstream consumer.
- irq  output  1  interrupt, registered.

Behaviour:
- Reset (rst_n=1 at posedge):
  - CTRL=0x00, SCRATCH=0xA5, overflow=0, underflow=0.
  - FIFO pointers and count=0.
  - data_r=0x00, irq=0.
  - tx_valid=0 follows from enable=0.
  - Reset mid-transaction discards that transaction and all FIFO contents.
- Register map (addresses outside the map: reads return 0x00, writes are ignored, no error):
  - 0x000 CTRL RW. bit0 enable; bit1 irq_en; bit7 fifo_clr, write-1 self-clearing, always reads 0; bits 6:2 reserved, read 0.
  - 0x001 STATUS. bit0 empty (RO); bit1 full (RO); bit2 overflow (sticky, W1C); bit3 underflow (sticky, W1C); others read 0.
  - 0x002 LEVEL RO. FIFO count, zero-extended to 8 bits.
  - 0x003 SCRATCH RW.
  - 0x004 FIFO_DATA. Write pushes data_w. Read returns the head without popping; an empty read returns 0x00 and sets underflow.
  - 0x005 ID RO. Returns ID_VALUE.
- Read timing:
  - A transaction with valid=1 and write_en=0 sampled at edge N updates data_r at edge N (visible during cycle N+1). Read latency is exactly 1 cycle.
  - data_r holds its value when no read occurs.
  - Read data reflects state before any same-cycle update. Example: a read of LEVEL during a stream pop returns the old count.
- Write timing: register updates take effect at the sampling edge.
- FIFO:
  - push = bus write to 0x004. pop = tx_valid & tx_ready.
  - tx_valid = CTRL.enable & !empty. tx_data = head entry (0x00 when empty).
  - Push while full without a same-cycle pop: data dropped, overflow set, count unchanged.
  - Push and pop in the same cycle: both occur and count is unchanged, including when full (push accepted) and when count=1.
  - Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
  - fifo_clr: pointers and count go to 0 at that edge. A push or pop in the same cycle is discarded. Sticky flags are unaffected.
  - Disabling enable stalls the drain; FIFO contents are retained.
- Flag priority: a W1C clear and a same-cycle set event leave the flag set.
- irq: registered, irq <= CTRL.irq_en & (overflow | underflow), using next-state values.

Decomposition:
- Package cthulhu_reg_pkg holds:
  - address constants ADDR_CTRL..ADDR_ID;
  - CTRL/STATUS bit-index constants;
  - the SCRATCH reset value 8'hA5;
  - a ctrl_t packed struct.
- Sub-module cthulhu_sync_fifo: a parameterised DEPTH x 8 FIFO with push, pop, clr, full, empty, count and head outputs. The register decode, flags, irq and read mux stay in the top.

Test Plan:
- Reset then read 0x005, 0x003, 0x001 -> data_r = 0xC7, 0xA5, 0x01 respectively, each one cycle after its read strobe.
- enable=0; write 0x11,0x22,0x33 to 0x004; read 0x002 -> 0x03; read 0x004 -> 0x11, LEVEL still 0x03.
- With the FIFO holding those 3 bytes, write CTRL=0x01 with tx_ready=1 -> tx_data 0x11,0x22,0x33 on consecutive cycles, then tx_valid=0; STATUS reads 0x01.
- enable=0, irq_en=1; push 9 bytes with DEPTH=8 -> STATUS=0x06, irq=1 on the cycle after the 9th push, LEVEL=0x08. Write 0x04 to STATUS -> irq drops the next cycle, STATUS=0x02.
- Full FIFO, enable=1, tx_ready=1, push 0x5A in the same cycle -> LEVEL stays 0x08, no overflow, and 0x5A emerges as the 8th subsequent tx_data.
- Write CTRL=0x80 with 4 entries, then read CTRL -> 0x00, LEVEL -> 0x00. Read 0x004 -> 0x00 and underflow sets (STATUS=0x09). Assert reset mid-stream -> all outputs return to their reset values.

Source files
------------

// File: rtl/cthulhu_reg_pkg.sv
// cthulhu_reg_pkg
// Shared definitions for the cthulhu register slave: register addresses,
// CTRL/STATUS bit positions, reset values and the CTRL storage struct.
package cthulhu_reg_pkg;

    // Register map
    localparam logic [11:0] ADDR_CTRL    = 12'h000;
    localparam logic [11:0] ADDR_STATUS  = 12'h001;
    localparam logic [11:0] ADDR_LEVEL   = 12'h002;
    localparam logic [11:0] ADDR_SCRATCH = 12'h003;
    localparam logic [11:0] ADDR_FIFO    = 12'h004;
    localparam logic [11:0] ADDR_ID      = 12'h005;

    // CTRL bit positions
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_FIFO_CLR = 7;

    // STATUS bit positions
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_UNDERFLOW = 3;

    localparam logic [7:0] SCRATCH_RST = 8'hA5;

    // Only the stored CTRL bits; fifo_clr is a pulse and is never stored.
    typedef struct packed {
        logic irq_en;
        logic enable;
    } ctrl_t;

    // Rebuild the CTRL byte as seen by software (reserved and fifo_clr read 0).
    function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
        logic [7:0] b;
        b              = 8'h00;
        b[CTRL_ENABLE] = c.enable;
        b[CTRL_IRQ_EN] = c.irq_en;
        return b;
    endfunction

endpackage

// File: rtl/cthulhu_sync_fifo.sv
// cthulhu_sync_fifo
// Single-clock DEPTH x WIDTH FIFO with occupancy count.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clr         synchronous flush; wins over a same-cycle push/pop
//   push, wdata write request and data; refused only when full with no pop
//   pop         read request; ignored when empty
//   head        oldest entry (undefined content when empty, caller masks)
//   full, empty occupancy flags
//   count       number of stored entries, 0..DEPTH
module cthulhu_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        // A push into a full FIFO is accepted when the head leaves in the
        // same cycle: the freed slot is exactly the one being written.
        push_ok  = push & (~full | pop);
        pop_ok   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cthulhu_reg_slave.sv
// cthulhu_reg_slave
// Register-bus slave holding CTRL/STATUS/LEVEL/SCRATCH/FIFO_DATA/ID registers
// and a byte TX FIFO that software fills by bus writes and a stream port drains.
// Ports:
//   clk       clock, posedge
//   rst_n     synchronous reset, ACTIVE HIGH despite the name
//   addr      12-bit register address
//   write_en  1 = write, 0 = read, qualified by valid
//   valid     transaction strobe, one transaction per cycle while high
//   data_w    write data
//   data_r    registered read data, updated one edge after the read strobe
//   tx_data   FIFO head byte (0x00 when empty)
//   tx_valid  stream valid
//   tx_ready  stream ready from the consumer
//   irq       registered level interrupt (irq_en & (overflow | underflow))
//
// Stream handshake: a byte transfers on every posedge where tx_valid and
// tx_ready are both high. tx_valid depends only on CTRL.enable and FIFO
// occupancy, never on tx_ready; the consumer may drive tx_ready freely.
module cthulhu_reg_slave
    import cthulhu_reg_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] ID_VALUE = 8'hC7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] addr,
    input  logic        write_en,
    input  logic        valid,
    input  logic [7:0]  data_w,
    output logic [7:0]  data_r,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ctrl_t            ctrl_q, ctrl_d;
    logic [7:0]       scratch_q, scratch_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [7:0]       data_r_q, data_r_d;
    logic             irq_q, irq_d;

    logic             rd_req;
    logic             wr_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic             ovf_set, ovf_clr;
    logic             udf_set, udf_clr;
    logic [7:0]       status_byte;
    logic [7:0]       rdata;

    cthulhu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (data_w),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_valid = ctrl_q.enable & ~fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_head;
    assign data_r   = data_r_q;
    assign irq      = irq_q;

    always_comb begin
        rd_req    = valid & ~write_en;
        wr_req    = valid & write_en;
        fifo_pop  = tx_valid & tx_ready;
        fifo_push = wr_req & (addr == ADDR_FIFO);
        fifo_clr  = wr_req & (addr == ADDR_CTRL) & data_w[CTRL_FIFO_CLR];

        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        if (wr_req && addr == ADDR_CTRL) begin
            ctrl_d.enable = data_w[CTRL_ENABLE];
            ctrl_d.irq_en = data_w[CTRL_IRQ_EN];
        end
        if (wr_req && addr == ADDR_SCRATCH) begin
            scratch_d = data_w;
        end

        // Set events win over a same-cycle W1C.
        ovf_set = fifo_push & fifo_full & ~fifo_pop;
        udf_set = rd_req & (addr == ADDR_FIFO) & fifo_empty;
        ovf_clr = wr_req & (addr == ADDR_STATUS) & data_w[STAT_OVERFLOW];
        udf_clr = wr_req & (addr == ADDR_STATUS) & data_w[STAT_UNDERFLOW];
        ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
        udf_d   = (udf_q & ~udf_clr) | udf_set;
        irq_d   = ctrl_d.irq_en & (ovf_d | udf_d);

        status_byte                 = 8'h00;
        status_byte[STAT_EMPTY]     = fifo_empty;
        status_byte[STAT_FULL]      = fifo_full;
        status_byte[STAT_OVERFLOW]  = ovf_q;
        status_byte[STAT_UNDERFLOW] = udf_q;

        // Read mux uses pre-edge state so a read racing an update sees old data.
        case (addr)
            ADDR_CTRL:    rdata = ctrl_to_byte(ctrl_q);
            ADDR_STATUS:  rdata = status_byte;
            ADDR_LEVEL:   rdata = 8'(fifo_count);
            ADDR_SCRATCH: rdata = scratch_q;
            ADDR_FIFO:    rdata = fifo_empty ? 8'h00 : fifo_head;
            ADDR_ID:      rdata = ID_VALUE;
            default:      rdata = 8'h00;
        endcase

        data_r_d = rd_req ? rdata : data_r_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ctrl_q    <= '0;
            scratch_q <= SCRATCH_RST;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            data_r_q  <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            data_r_q  <= data_r_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_cthulhu_reg_slave.sv
// Directed bench for cthulhu_reg_slave. Inputs change #1 after posedge,
// outputs are sampled at the same point, so each task call is one bus cycle.
module tb_cthulhu_reg_slave;

    logic        clk;
    logic        rst_n;
    logic [11:0] addr;
    logic        write_en;
    logic        valid;
    logic [7:0]  data_w;
    logic [7:0]  data_r;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    cthulhu_reg_slave #(.DEPTH(8), .ID_VALUE(8'hC7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .write_en (write_en),
        .valid    (valid),
        .data_w   (data_w),
        .data_r   (data_r),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
        addr = a; write_en = 1'b1; data_w = d; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [7:0] d);
        addr = a; write_en = 1'b0; data_w = 8'h00; valid = 1'b1;
        @(posedge clk); #1;
        d = data_r;
        valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst_n = 1'b1; valid = 1'b0; write_en = 1'b0; addr = '0; data_w = '0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (data_r !== 8'h00) begin err_cnt++; $display("FAIL rst_data_r: got %02h required 00", data_r); end
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL rst_irq: got %b required 0", irq); end
        vec_cnt++; if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_tx_valid: got %b required 0", tx_valid); end
        vec_cnt++; if (tx_data !== 8'h00) begin err_cnt++; $display("FAIL rst_tx_data: got %02h required 00", tx_data); end
        rst_n = 1'b0;
        // back-to-back reads, one cycle latency each
        bus_read(12'h005, rd);
        vec_cnt++; if (rd !== 8'hC7) begin err_cnt++; $display("FAIL id_read: got %02h required C7", rd); end
        bus_read(12'h003, rd);
        vec_cnt++; if (rd !== 8'hA5) begin err_cnt++; $display("FAIL scratch_rst: got %02h required A5", rd); end
        bus_read(12'h001, rd);
        vec_cnt++; if (rd !== 8'h01) begin err_cnt++; $display("FAIL status_rst: got %02h required 01", rd); end
    endtask

    task automatic test_registers();
        logic [7:0] rd;
        bus_write(12'h003, 8'h3C);
        bus_read(12'h003, rd);
        vec_cnt++; if (rd !== 8'h3C) begin err_cnt++; $display("FAIL scratch_rw: got %02h required 3C", rd); end
        idle_cycle();
        vec_cnt++; if (data_r !== 8'h3C) begin err_cnt++; $display("FAIL data_r_hold: got %02h required 3C", data_r); end
        bus_write(12'h006, 8'hFF);
        bus_read(12'h006, rd);
        vec_cnt++; if (rd !== 8'h00) begin err_cnt++; $display("FAIL unmapped_006: got %02h required 00", rd); end
        bus_read(12'h800, rd);
        vec_cnt++; if (rd !== 8'h00) begin err_cnt++; $display("FAIL unmapped_800: got %02h required 00", rd); end
        // reserved bits and fifo_clr read back as 0
        bus_write(12'h000, 8'hFF);
        bus_read(12'h000, rd);
        vec_cnt++; if (rd !== 8'h03) begin err_cnt++; $display("FAIL ctrl_mask: got %02h required 03", rd); end
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL ctrl_irq_noflag: got %b required 0", irq); end
        bus_write(12'h000, 8'h00);
    endtask

    task automatic test_fill();
        logic [7:0] rd;
        bus_write(12'h004, 8'h11);
        bus_write(12'h004, 8'h22);
        bus_write(12'h004, 8'h33);
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h03) begin err_cnt++; $display("FAIL fill_level: got %02h required 03", rd); end
        bus_read(12'h004, rd);
        vec_cnt++; if (rd !== 8'h11) begin err_cnt++; $display("FAIL fill_peek: got %02h required 11", rd); end
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h03) begin err_cnt++; $display("FAIL fill_level_after_peek: got %02h required 03", rd); end
        vec_cnt++; if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL fill_disabled_valid: got %b required 0", tx_valid); end
        vec_cnt++; if (tx_data !== 8'h11) begin err_cnt++; $display("FAIL fill_head: got %02h required 11", tx_data); end
    endtask

    task automatic test_drain();
        logic [7:0] rd;
        tx_ready = 1'b1;
        bus_write(12'h000, 8'h01);
        vec_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin err_cnt++; $display("FAIL drain_0: got v=%b d=%02h required v=1 d=11", tx_valid, tx_data); end
        // read LEVEL while the first pop happens: old count returned
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h03) begin err_cnt++; $display("FAIL drain_level_race: got %02h required 03", rd); end
        vec_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin err_cnt++; $display("FAIL drain_1: got v=%b d=%02h required v=1 d=22", tx_valid, tx_data); end
        idle_cycle();
        vec_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin err_cnt++; $display("FAIL drain_2: got v=%b d=%02h required v=1 d=33", tx_valid, tx_data); end
        idle_cycle();
        vec_cnt++; if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_empty_valid: got %b required 0", tx_valid); end
        bus_read(12'h001, rd);
        vec_cnt++; if (rd !== 8'h01) begin err_cnt++; $display("FAIL drain_status: got %02h required 01", rd); end
    endtask

    task automatic test_overflow();
        logic [7:0] rd;
        bus_write(12'h000, 8'h02);
        for (int i = 0; i < 9; i++) begin
            bus_write(12'h004, 8'h80 + 8'(i));
            if (i == 7) begin
                vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL ovf_irq_early: got %b required 0", irq); end
            end
        end
        vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL ovf_irq: got %b required 1", irq); end
        bus_read(12'h001, rd);
        vec_cnt++; if (rd !== 8'h06) begin err_cnt++; $display("FAIL ovf_status: got %02h required 06", rd); end
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h08) begin err_cnt++; $display("FAIL ovf_level: got %02h required 08", rd); end
        vec_cnt++; if (tx_data !== 8'h80) begin err_cnt++; $display("FAIL ovf_head: got %02h required 80", tx_data); end
        bus_write(12'h001, 8'h04);
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL ovf_w1c_irq: got %b required 0", irq); end
        bus_read(12'h001, rd);
        vec_cnt++; if (rd !== 8'h02) begin err_cnt++; $display("FAIL ovf_w1c_status: got %02h required 02", rd); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] rd;
        logic [7:0] exp_bytes [8];
        exp_bytes = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h5A};
        tx_ready = 1'b0;
        bus_write(12'h000, 8'h03);
        vec_cnt++; if (tx_valid !== 1'b1) begin err_cnt++; $display("FAIL fpp_valid: got %b required 1", tx_valid); end
        tx_ready = 1'b1;
        bus_write(12'h004, 8'h5A);
        tx_ready = 1'b0;
        vec_cnt++; if (tx_data !== 8'h81) begin err_cnt++; $display("FAIL fpp_head: got %02h required 81", tx_data); end
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h08) begin err_cnt++; $display("FAIL fpp_level: got %02h required 08", rd); end
        bus_read(12'h001, rd);
        vec_cnt++; if (rd !== 8'h02) begin err_cnt++; $display("FAIL fpp_status: got %02h required 02", rd); end
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL fpp_irq: got %b required 0", irq); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin
                err_cnt++;
                $display("FAIL fpp_drain_%0d: got v=%b d=%02h required v=1 d=%02h", i, tx_valid, tx_data, exp_bytes[i]);
            end
            idle_cycle();
        end
        vec_cnt++; if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL fpp_empty: got %b required 0", tx_valid); end
    endtask

    task automatic test_clear_underflow();
        logic [7:0] rd;
        bus_write(12'h000, 8'h00);
        for (int i = 0; i < 4; i++) bus_write(12'h004, 8'hA1 + 8'(i));
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h04) begin err_cnt++; $display("FAIL clr_pre_level: got %02h required 04", rd); end
        bus_write(12'h000, 8'h80);
        bus_read(12'h000, rd);
        vec_cnt++; if (rd !== 8'h00) begin err_cnt++; $display("FAIL clr_ctrl: got %02h required 00", rd); end
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h00) begin err_cnt++; $display("FAIL clr_level: got %02h required 00", rd); end
        bus_read(12'h004, rd);
        vec_cnt++; if (rd !== 8'h00) begin err_cnt++; $display("FAIL udf_read: got %02h required 00", rd); end
        bus_read(12'h001, rd);
        vec_cnt++; if (rd !== 8'h09) begin err_cnt++; $display("FAIL udf_status: got %02h required 09", rd); end
        vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL udf_irq_masked: got %b required 0", irq); end
        bus_write(12'h000, 8'h02);
        vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL udf_irq: got %b required 1", irq); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        tx_ready = 1'b0;
        bus_write(12'h000, 8'h03);
        bus_write(12'h004, 8'hC1);
        bus_write(12'h004, 8'hC2);
        bus_read(12'h001, rd);
        vec_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'hC1 || irq !== 1'b1) begin err_cnt++; $display("FAIL mid_pre: got v=%b d=%02h irq=%b required v=1 d=C1 irq=1", tx_valid, tx_data, irq); end
        // reset lands on a SCRATCH write, which must be discarded
        addr = 12'h003; write_en = 1'b1; data_w = 8'h77; valid = 1'b1; tx_ready = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; write_en = 1'b0; rst_n = 1'b0; tx_ready = 1'b0;
        vec_cnt++; if (data_r !== 8'h00 || irq !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            err_cnt++; $display("FAIL mid_reset_outs: got r=%02h irq=%b v=%b d=%02h required 00 0 0 00", data_r, irq, tx_valid, tx_data);
        end
        bus_read(12'h003, rd);
        vec_cnt++; if (rd !== 8'hA5) begin err_cnt++; $display("FAIL mid_scratch: got %02h required A5", rd); end
        bus_read(12'h002, rd);
        vec_cnt++; if (rd !== 8'h00) begin err_cnt++; $display("FAIL mid_level: got %02h required 00", rd); end
        bus_read(12'h000, rd);
        vec_cnt++; if (rd !== 8'h00) begin err_cnt++; $display("FAIL mid_ctrl: got %02h required 00", rd); end
        bus_read(12'h001, rd);
        vec_cnt++; if (rd !== 8'h01) begin err_cnt++; $display("FAIL mid_status: got %02h required 01", rd); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_fill();
        test_drain();
        test_overflow();
        test_full_push_pop();
        test_clear_underflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
